// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU datapath.
//   - DW_DEFAULT / RW_DEFAULT: default datapath and register-index widths
//   - OP_*: 4-bit opcode encodings
//   - flag_class_e / flag_class(): how an opcode affects the Z/V/N flags
//   - pipe_state_e: run/halt state of the EX->MEM stage
// Build option: FLAG_FWD_EN (see ex_mem_pipe.sv) uses nothing extra from here.
package cpu_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int RW_DEFAULT = 4;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [1:0] {
    FL_NONE = 2'd0,
    FL_Z    = 2'd1,
    FL_ALL  = 2'd2
  } flag_class_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pipe_state_e;

  // PADDSB deliberately falls into FL_NONE: a saturated zero must not set Z.
  function automatic flag_class_e flag_class(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB:                 flag_class = FL_ALL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_class = FL_Z;
      default:                        flag_class = FL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if: EX-side inputs and MEM-side outputs of the EX->MEM stage.
//   ex_*  : instruction presented by EX (valid, opcode, ALU result, overflow,
//           store data, destination, writeback/load/store enables)
//   mem_* : registered copy handed to MEM (enables already gated by valid)
// Modports: master drives ex_* and observes mem_*; slave is the pipe stage.
interface ex_mem_pipe_if #(
  parameter int DW = cpu_pkg::DW_DEFAULT,
  parameter int RW = cpu_pkg::RW_DEFAULT
);
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [DW-1:0] ex_alu_out;
  logic          ex_ovfl;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_wr;
  logic          ex_mem_rd;
  logic          ex_mem_wr;

  logic          mem_valid;
  logic [DW-1:0] mem_alu_out;
  logic [DW-1:0] mem_store_data;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_wr;
  logic          mem_mem_rd;
  logic          mem_mem_wr;

  modport master (
    output ex_valid, ex_opcode, ex_alu_out, ex_ovfl, ex_store_data,
           ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr,
    input  mem_valid, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_wr, mem_mem_rd, mem_mem_wr
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_alu_out, ex_ovfl, ex_store_data,
           ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr,
    output mem_valid, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_wr, mem_mem_rd, mem_mem_wr
  );
endinterface

// File: rtl/flag_reg.sv
// flag_reg: architectural Z/V/N flag register.
//   clk, rst      : clock, synchronous active-high reset
//   accept        : the instruction in EX is being taken this edge
//   fclass        : flag-update class of that instruction's opcode
//   result, ovfl  : ALU result and signed-overflow bit
//   flag_z/v/n    : registered flags
//   next_z/v/n    : (FLAG_FWD_EN only) value the flags take on this edge
module flag_reg
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  flag_class_e   fclass,
  input  logic [DW-1:0] result,
  input  logic          ovfl,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n
`ifdef FLAG_FWD_EN
  ,
  output logic          next_z,
  output logic          next_v,
  output logic          next_n
`endif
);

  logic nz, nv, nn;

  // Reset is folded into the next-state so the forwarded view also reads 0.
  always_comb begin
    nz = flag_z;
    nv = flag_v;
    nn = flag_n;
    if (rst) begin
      nz = 1'b0;
      nv = 1'b0;
      nn = 1'b0;
    end else if (accept) begin
      case (fclass)
        FL_ALL: begin
          nz = (result == '0);
          nv = ovfl;
          nn = result[DW-1];
        end
        FL_Z:    nz = (result == '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      flag_z <= nz;
      flag_v <= nv;
      flag_n <= nn;
    end
  end

`ifdef FLAG_FWD_EN
  assign next_z = nz;
  assign next_v = nv;
  assign next_n = nn;
`endif

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register of the 16-bit CPU.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hold every stage register and the flags
//   flush             : turn the incoming instruction into a bubble
//   bus (slave)       : ex_* instruction in, mem_* registered instruction out
//   flag_z/v/n        : architectural flags
//   halted            : sticky, set once an HLT has been accepted
// Build option FLAG_FWD_EN adds fwd_flag_z/v/n, the flag values that will be
// held after the current edge, so a branch can see the flags set by the
// instruction just ahead of it without waiting a cycle.
module ex_mem_pipe
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  ex_mem_pipe_if.slave bus,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        halted
`ifdef FLAG_FWD_EN
  ,
  output logic        fwd_flag_z,
  output logic        fwd_flag_v,
  output logic        fwd_flag_n
`endif
);

  pipe_state_e state_q, state_d;
  logic        accept;
  logic        is_hlt;

  assign is_hlt = (bus.ex_opcode == OP_HLT);
  assign accept = bus.ex_valid & ~stall & ~flush & (state_q == ST_RUN);
  assign halted = (state_q == ST_HALTED);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // accept already excludes flush, so a flushed HLT never halts.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && accept && is_hlt) state_d = ST_HALTED;
  end

  // Enables are gated by accept so bubbles never write; HLT travels down as
  // a valid instruction with every enable forced low. Data fields only load
  // while running, so a halted stage ignores whatever EX presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_alu_out    <= '0;
      bus.mem_store_data <= '0;
      bus.mem_rd         <= '0;
      bus.mem_reg_wr     <= 1'b0;
      bus.mem_mem_rd     <= 1'b0;
      bus.mem_mem_wr     <= 1'b0;
    end else if (flush) begin
      bus.mem_valid  <= 1'b0;
      bus.mem_reg_wr <= 1'b0;
      bus.mem_mem_rd <= 1'b0;
      bus.mem_mem_wr <= 1'b0;
    end else if (!stall) begin
      bus.mem_valid  <= accept;
      bus.mem_reg_wr <= accept & bus.ex_reg_wr & ~is_hlt;
      bus.mem_mem_rd <= accept & bus.ex_mem_rd & ~is_hlt;
      bus.mem_mem_wr <= accept & bus.ex_mem_wr & ~is_hlt;
      if (state_q == ST_RUN) begin
        bus.mem_alu_out    <= bus.ex_alu_out;
        bus.mem_store_data <= bus.ex_store_data;
        bus.mem_rd         <= bus.ex_rd;
      end
    end
  end

  flag_reg #(.DW(DW)) u_flag_reg (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .fclass (flag_class(bus.ex_opcode)),
    .result (bus.ex_alu_out),
    .ovfl   (bus.ex_ovfl),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n)
`ifdef FLAG_FWD_EN
    ,
    .next_z (fwd_flag_z),
    .next_v (fwd_flag_v),
    .next_n (fwd_flag_n)
`endif
  );

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- EX→MEM pipeline stage of the 16-bit CPU datapath. Sits directly downstream of the ALU, which contains the adder, PADDSB, shifters and RED.
- Registers the ALU result and control for the MEM stage.
- Owns the architectural Z/V/N flag register, applying per-opcode flag-update rules.
- Tracks HLT: once halted, the stage stops accepting instructions.

Parameters:
- DW, 16, datapath width
- RW, 4, register-index width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage registers and flags
- flush  in  1  replace incoming instruction with a bubble
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  4  instruction opcode
- ex_alu_out  in  DW  ALU result (includes saturated PADDSB result)
- ex_ovfl  in  1  signed overflow from ADD/SUB adder
- ex_store_data  in  DW  rt value for SW
- ex_rd  in  RW  destination register
- ex_reg_wr  in  1  writeback enable
- ex_mem_rd  in  1  load
- ex_mem_wr  in  1  store
- mem_valid  out  1  MEM stage holds a real instruction
- mem_alu_out  out  DW  registered result / address
- mem_store_data  out  DW  registered store data
- mem_rd  out  RW  registered destination
- mem_reg_wr  out  1  registered writeback enable, gated by valid
- mem_mem_rd  out  1  registered load enable, gated by valid
- mem_mem_wr  out  1  registered store enable, gated by valid
- flag_z  out  1  zero flag
- flag_v  out  1  overflow flag
- flag_n  out  1  negative flag
- halted  out  1  sticky; HLT has entered the stage

Behaviour:
- Reset: every output is 0, including flags and halted; the FSM enters RUN. Reset overrides stall, flush and any in-flight instruction.
- Latency: exactly 1 cycle EX→MEM when not stalled.
- Accept condition: accept = ex_valid & ~stall & ~flush & ~halted.

Priority each cycle: rst > flush > stall > normal.
- flush=1, regardless of stall: mem_valid←0; mem_reg_wr, mem_mem_rd and mem_mem_wr←0; data fields may hold; flags unchanged.
- stall=1 with flush=0: all registers and flags hold.
- Normal: all mem_* fields load from ex_*, and mem_valid←accept. Control outputs are ANDed with accept, so a bubble never writes.

Flag update, only on the accept edge, using ex_alu_out:
- ADD (0000), SUB (0001):
  - Z←(ex_alu_out==0)
  - V←ex_ovfl
  - N←ex_alu_out[DW-1]
- XOR (0010), SLL (0100), SRA (0101), ROR (0110): Z only; V and N hold.
- All other opcodes, including PADDSB (0111), RED, LW, SW, LLB, LHB, branches, PCS and HLT: no flag change.
- A PADDSB result of 0x0000 does not set Z.

FSM:
- Two states, RUN and HALTED.
- RUN→HALTED on accept with opcode 1111. The HLT itself propagates as a valid instruction with all write enables 0.
- In HALTED: halted=1, and mem_valid←0 each non-stalled cycle. ex_* is ignored and flags are frozen.
- Only rst exits HALTED.
- A flushed HLT does not halt.

Optional Feature:
- Macro: FLAG_FWD_EN.
- When defined:
  - Adds outputs fwd_flag_z, fwd_flag_v, fwd_flag_n (1 bit each).
  - These show the flag values that will be held after the current edge, i.e. the combinational next-state, so that a branch in the EX-adjacent stage sees flags set by the instruction immediately ahead.
- When undefined: those ports are absent, and branches see only the registered flags, which is one cycle later.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_ADD…OP_HLT
  - DW/RW defaults
  - a flag-update-class encoding (FL_ALL, FL_Z, FL_NONE) with a function mapping opcode→class
- One sub-module, flag_reg: holds Z/V/N, takes accept, opcode class, result and ovfl, and provides the next-state output used by FLAG_FWD_EN.

Test Plan:
- Reset, then ADD with alu_out=0x0000, ovfl=0 → next cycle mem_valid=1, Z=1, V=0, N=0.
- SUB with alu_out=0x8000, ovfl=1 → Z=0, V=1, N=1. Follow with PADDSB giving 0x0000 → flags unchanged (Z=0, V=1, N=1).
- XOR with 0x0000 after V=1, N=1 → Z=1, V=1, N=1.
- stall=1 for 3 cycles while ex_* changes → all mem_* and flags hold. Then assert stall=1 and flush=1 together → mem_valid=0 and write enables 0.
- SW (mem_wr=1) with flush=1 → mem_mem_wr=0 and no flag change. The same SW unflushed → mem_mem_wr=1 and mem_store_data matches the input.
- HLT accepted → halted=1 next cycle. A following ADD with 0x0000 leaves Z unchanged and mem_valid=0. rst=1 for one cycle → halted=0 and all outputs 0. With FLAG_FWD_EN, fwd_flag_z=1 in the same cycle as an accepted ADD with 0x0000.
